// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with EX-stage operand forwarding.
//   Captures decoded operands, specifiers and controls from ID, then forwards
//   EX/MEM and MEM/WB results onto the ALU operands combinationally.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold all state / load a bubble (flush beats stall)
//   id_*                decode-stage operands, specifiers and controls
//   exm_*               EX/MEM forwarding source (newest)
//   wb_*                MEM/WB forwarding source
//   alu_a, alu_b        forwarded ALU operands (alu_b may be the immediate)
//   alu_control         registered ALU op code
//   store_data          forwarded rt value for stores
//   write_reg           registered destination register
//   ex_*                registered memory/writeback controls
//   fwd_a, fwd_b        forwarding selects: 00 reg, 01 WB, 10 EX/MEM
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_EXM = 2'b10;

  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
  logic [4:0]        r_rs, r_rt, r_write_reg;
  logic [3:0]        r_alu_control;
  logic              r_alu_src, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;

  logic [DATA_W-1:0] w_rs_fwd, w_rt_fwd;
  logic [1:0]        w_fwd_a, w_fwd_b;

  // Reset and flush both produce an all-zero bubble; reset is listed first
  // only for readability, the outcome is identical.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_write_reg   <= '0;
      r_alu_control <= '0;
      r_alu_src     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
    end else if (!stall) begin
      r_rs_data     <= id_rs_data;
      r_rt_data     <= id_rt_data;
      r_imm         <= id_imm;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      // Destination resolved at capture so reg_dst need not be stored.
      r_write_reg   <= id_reg_dst ? id_rd : id_rt;
      r_alu_control <= id_alu_control;
      r_alu_src     <= id_alu_src;
      r_reg_write   <= id_reg_write;
      r_mem_read    <= id_mem_read;
      r_mem_write   <= id_mem_write;
      r_mem_to_reg  <= id_mem_to_reg;
    end
  end

  // EX/MEM checked first so the newest producer wins; $zero never forwards.
  always_comb begin
    w_fwd_a = FWD_REG;
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rs))
      w_fwd_a = FWD_EXM;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs))
      w_fwd_a = FWD_WB;
  end

  always_comb begin
    w_fwd_b = FWD_REG;
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rt))
      w_fwd_b = FWD_EXM;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rt))
      w_fwd_b = FWD_WB;
  end

  always_comb begin
    case (w_fwd_a)
      FWD_EXM: w_rs_fwd = exm_result;
      FWD_WB:  w_rs_fwd = wb_data;
      default: w_rs_fwd = r_rs_data;
    endcase
  end

  always_comb begin
    case (w_fwd_b)
      FWD_EXM: w_rt_fwd = exm_result;
      FWD_WB:  w_rt_fwd = wb_data;
      default: w_rt_fwd = r_rt_data;
    endcase
  end

  // Forwarding mux sits ahead of the immediate select.
  assign alu_a         = w_rs_fwd;
  assign alu_b         = r_alu_src ? r_imm : w_rt_fwd;
  assign store_data    = w_rt_fwd;
  assign fwd_a         = w_fwd_a;
  assign fwd_b         = w_fwd_b;
  assign alu_control   = r_alu_control;
  assign write_reg     = r_write_reg;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule
